// File: rtl/coin_acceptor.sv
// coin_acceptor: front end of the vending-machine controller.
//
// Debounces the raw coin sensor, classifies the coin code into a value in sen,
// buffers accepted coins in a small FIFO and hands them to the controller one
// at a time whenever it signals it can take a coin. Invalid coins, coins that
// arrive while the FIFO is full and coins landing on a flush are rejected back
// to the return chute.
//
// Parameters:
//   DEPTH     FIFO entries (power of 2, 2..16)
//   DEBOUNCE  consecutive identical sensor samples needed to accept an edge (>= 2)
//   GAP       idle cycles forced after each deposited pulse (>= 0)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   coin_sense   raw sensor level, high while a coin is in the slot
//   coin_type    coin code, valid while coin_sense is high
//   accept       controller can take a deposit this cycle
//   flush        synchronous clear of all buffered coins
//   deposit      value of the coin presented, in sen (holds between pulses)
//   deposited    one-cycle strobe: deposit valid, coin consumed
//   coin_reject  one-cycle strobe: coin diverted to the return chute
//   empty        FIFO empty
//   full         FIFO full
//   count        entries held

module coin_acceptor #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned GAP      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coin_sense,
    input  logic [2:0]               coin_type,
    input  logic                     accept,
    input  logic                     flush,
    output logic [9:0]               deposit,
    output logic                     deposited,
    output logic                     coin_reject,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = $clog2(DEBOUNCE + 1);
    localparam int unsigned GW   = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [CW-1:0]   DB_LAST   = CW'(DEBOUNCE);
    localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(DEPTH);
    localparam logic [GW-1:0]   GAP_LOAD  = GW'(GAP);

    typedef enum logic [2:0] {
        StLock,
        StIdle,
        StRise,
        StHeld,
        StFall
    } db_state_e;

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    db_state_e     state_q, state_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [CW-1:0] db_cnt_inc;
    logic          coin_ev_d, coin_ev_q;
    logic [2:0]    coin_code_q;

    assign db_cnt_inc = db_cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        coin_ev_d = 1'b0;
        unique case (state_q)
            // Sensor may already be high when reset releases; insist on a
            // quiet slot before arming so that level is not taken as a coin.
            StLock: begin
                if (coin_sense) begin
                    db_cnt_d = '0;
                end else if (db_cnt_inc == DB_LAST) begin
                    state_d  = StIdle;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_inc;
                end
            end
            StIdle: begin
                if (coin_sense) begin
                    state_d  = StRise;
                    db_cnt_d = CW'(1);
                end
            end
            StRise: begin
                if (!coin_sense) begin
                    state_d  = StIdle;
                    db_cnt_d = '0;
                end else if (db_cnt_inc == DB_LAST) begin
                    state_d   = StHeld;
                    db_cnt_d  = '0;
                    coin_ev_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_inc;
                end
            end
            StHeld: begin
                if (!coin_sense) begin
                    state_d  = StFall;
                    db_cnt_d = CW'(1);
                end
            end
            StFall: begin
                if (coin_sense) begin
                    state_d  = StHeld;
                    db_cnt_d = '0;
                end else if (db_cnt_inc == DB_LAST) begin
                    state_d  = StIdle;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_inc;
                end
            end
            default: begin
                state_d  = StLock;
                db_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StLock;
            db_cnt_q    <= '0;
            coin_ev_q   <= 1'b0;
            coin_code_q <= '0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            coin_ev_q <= coin_ev_d;
            if (coin_ev_d) begin
                coin_code_q <= coin_type;
            end
        end
    end

    // ------------------------------------------------------------------
    // Classification of the captured code
    // ------------------------------------------------------------------
    logic       coin_valid;
    logic [9:0] coin_value;

    always_comb begin
        coin_valid = 1'b1;
        coin_value = '0;
        unique case (coin_code_q)
            3'd0:    coin_value = 10'd5;
            3'd1:    coin_value = 10'd10;
            3'd2:    coin_value = 10'd20;
            3'd3:    coin_value = 10'd50;
            3'd4:    coin_value = 10'd100;
            default: coin_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO and output stage
    // ------------------------------------------------------------------
    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic [GW-1:0]   gap_q;
    logic [9:0]      deposit_q;
    logic            deposited_q;
    logic            coin_reject_q;
    logic            push, pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;

    // full is taken from the registered count, so a pop on the same edge
    // does not make room for the incoming coin.
    assign push = coin_ev_q & coin_valid & ~full & ~flush;
    assign pop  = ~empty & accept & (gap_q == '0) & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            gap_q         <= '0;
            deposit_q     <= '0;
            deposited_q   <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            deposited_q   <= pop;
            coin_reject_q <= coin_ev_q & ~push;
            if (pop) begin
                deposit_q <= mem[rd_ptr_q];
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                gap_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + CNTW'(1);
                    2'b01:   count_q <= count_q - CNTW'(1);
                    default: count_q <= count_q;
                endcase
                if (pop) begin
                    gap_q <= GAP_LOAD;
                end else if (gap_q != '0) begin
                    gap_q <= gap_q - GW'(1);
                end
            end
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= coin_value;
        end
    end

    assign deposit     = deposit_q;
    assign deposited   = deposited_q;
    assign coin_reject = coin_reject_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with default parameters
// (DEPTH=4, DEBOUNCE=4, GAP=2). Inputs change on the falling edge, outputs
// are sampled on the falling edge.

module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_sense;
    logic [2:0] coin_type;
    logic       accept;
    logic       flush;
    logic [9:0] deposit;
    logic       deposited;
    logic       coin_reject;
    logic       empty;
    logic       full;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    int max_count = 0;
    logic [9:0] dep_log[$];

    coin_acceptor #(
        .DEPTH    (4),
        .DEBOUNCE (4),
        .GAP      (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_sense  (coin_sense),
        .coin_type   (coin_type),
        .accept      (accept),
        .flush       (flush),
        .deposit     (deposit),
        .deposited   (deposited),
        .coin_reject (coin_reject),
        .empty       (empty),
        .full        (full),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Record every deposited coin and the deepest FIFO occupancy seen.
    always @(negedge clk) begin
        if (rst === 1'b1 && deposited === 1'b1) dep_log.push_back(deposit);
        if (int'(count) > max_count) max_count = int'(count);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Clean coin: 6 high samples then 5 low samples; counts reject pulses seen.
    task automatic insert_coin(input logic [2:0] t, output int rej);
        rej = 0;
        coin_type  = t;
        coin_sense = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (coin_reject === 1'b1) rej++;
            if (i == 6) coin_sense = 1'b0;
        end
    endtask

    task automatic test_reset();
        int rej;
        rej = 0;
        repeat (2) @(negedge clk);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b required 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b required 0", full); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", count); end
        n_checks++; if (deposited !== 1'b0) begin n_fail++; $display("FAIL reset_deposited: got %b required 0", deposited); end
        n_checks++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL reset_reject: got %b required 0", coin_reject); end
        n_checks++; if (deposit !== 10'd0) begin n_fail++; $display("FAIL reset_deposit: got %0d required 0", deposit); end
        rst = 1'b1;
        // Sensor stuck high across reset release must not register a coin.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (coin_reject === 1'b1) rej++;
        end
        coin_sense = 1'b0;
        repeat (3) @(negedge clk);
        coin_sense = 1'b1;
        repeat (6) @(negedge clk);
        coin_sense = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL lock_no_event: count got %0d required 0", count); end
        n_checks++; if (rej !== 0) begin n_fail++; $display("FAIL lock_no_reject: got %0d required 0", rej); end
        insert_coin(3'd0, rej);
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL lock_then_coin: count got %0d required 1", count); end
        dep_log.delete();
        accept = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (dep_log.size() !== 1) begin n_fail++; $display("FAIL lock_coin_out: got %0d pulses required 1", dep_log.size()); end
        else begin
            n_checks++; if (dep_log[0] !== 10'd5) begin n_fail++; $display("FAIL lock_coin_value: got %0d required 5", dep_log[0]); end
        end
    endtask

    task automatic test_glitch();
        coin_type  = 3'd3;
        coin_sense = 1'b1;
        repeat (3) @(negedge clk);
        coin_sense = 1'b0;
        @(negedge clk);
        coin_sense = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (deposited !== (i == 6)) begin
                n_fail++; $display("FAIL glitch_deposited[%0d]: got %b required %b", i, deposited, (i == 6));
            end
            if (i == 5) begin
                n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL glitch_write: count got %0d required 1", count); end
            end
            if (i == 6) begin
                n_checks++; if (deposit !== 10'd50) begin n_fail++; $display("FAIL glitch_value: got %0d required 50", deposit); end
                coin_sense = 1'b0;
            end
        end
    endtask

    task automatic test_invalid();
        coin_type  = 3'd6;
        coin_sense = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (coin_reject !== (i == 5)) begin
                n_fail++; $display("FAIL invalid_reject[%0d]: got %b required %b", i, coin_reject, (i == 5));
            end
            n_checks++; if (deposited !== 1'b0) begin n_fail++; $display("FAIL invalid_deposited[%0d]: got %b required 0", i, deposited); end
            n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL invalid_count[%0d]: got %0d required 0", i, count); end
            if (i == 6) coin_sense = 1'b0;
        end
    endtask

    task automatic test_full();
        logic [2:0] codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3};
        logic [9:0] vals  [4] = '{10'd5, 10'd10, 10'd20, 10'd100};
        int rej;
        int k;
        logic exp_dep;
        accept = 1'b0;
        for (int c = 0; c < 4; c++) insert_coin(codes[c], rej);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d required 4", count); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b required 1", full); end
        insert_coin(codes[4], rej);
        n_checks++; if (rej !== 1) begin n_fail++; $display("FAIL full_reject: got %0d pulses required 1", rej); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count_after: got %0d required 4", count); end
        k = 0;
        accept = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            exp_dep = (i == 1 || i == 4 || i == 7 || i == 10);
            n_checks++;
            if (deposited !== exp_dep) begin
                n_fail++; $display("FAIL drain_deposited[%0d]: got %b required %b", i, deposited, exp_dep);
            end
            if (exp_dep) begin
                n_checks++;
                if (deposit !== vals[k]) begin n_fail++; $display("FAIL drain_value[%0d]: got %0d required %0d", k, deposit, vals[k]); end
                k++;
            end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b required 1", empty); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d required 0", count); end
    endtask

    task automatic test_wrap();
        logic [2:0] codes [6] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
        logic [9:0] vals  [6] = '{10'd100, 10'd50, 10'd20, 10'd10, 10'd5, 10'd100};
        int rej;
        dep_log.delete();
        max_count = 0;
        accept = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) accept = 1'b1;
            insert_coin(codes[c], rej);
        end
        repeat (10) @(negedge clk);
        n_checks++; if (dep_log.size() !== 6) begin n_fail++; $display("FAIL wrap_pulses: got %0d required 6", dep_log.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (dep_log[i] !== vals[i]) begin n_fail++; $display("FAIL wrap_order[%0d]: got %0d required %0d", i, dep_log[i], vals[i]); end
            end
        end
        n_checks++; if (max_count > 4) begin n_fail++; $display("FAIL wrap_max_count: got %0d required <=4", max_count); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_final_count: got %0d required 0", count); end
    endtask

    // Coin write and pop on the same edge, first with the FIFO full, then not.
    task automatic test_push_pop();
        logic [2:0] codes [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [9:0] vals  [3] = '{10'd20, 10'd50, 10'd100};
        logic       exp_rej [2] = '{1'b1, 1'b0};
        logic [9:0] exp_val [2] = '{10'd5, 10'd10};
        int rej;
        accept = 1'b0;
        for (int c = 0; c < 4; c++) insert_coin(codes[c], rej);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL pp_full: got %b required 1", full); end
        for (int r = 0; r < 2; r++) begin
            coin_type  = 3'd4;
            coin_sense = 1'b1;
            for (int i = 1; i <= 11; i++) begin
                @(negedge clk);
                if (i == 4) accept = 1'b1;
                if (i == 5) begin
                    n_checks++; if (coin_reject !== exp_rej[r]) begin n_fail++; $display("FAIL pp_reject[%0d]: got %b required %b", r, coin_reject, exp_rej[r]); end
                    n_checks++; if (deposited !== 1'b1) begin n_fail++; $display("FAIL pp_deposited[%0d]: got %b required 1", r, deposited); end
                    n_checks++; if (deposit !== exp_val[r]) begin n_fail++; $display("FAIL pp_value[%0d]: got %0d required %0d", r, deposit, exp_val[r]); end
                    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL pp_count[%0d]: got %0d required 3", r, count); end
                    accept = 1'b0;
                end
                if (i == 6) coin_sense = 1'b0;
            end
        end
        dep_log.delete();
        accept = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++; if (dep_log.size() !== 3) begin n_fail++; $display("FAIL pp_drain: got %0d pulses required 3", dep_log.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (dep_log[i] !== vals[i]) begin n_fail++; $display("FAIL pp_order[%0d]: got %0d required %0d", i, dep_log[i], vals[i]); end
            end
        end
    endtask

    task automatic test_flush();
        int rej;
        accept = 1'b0;
        dep_log.delete();
        insert_coin(3'd0, rej);
        insert_coin(3'd1, rej);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL flush_pre_count: got %0d required 2", count); end
        coin_type  = 3'd2;
        coin_sense = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 4) begin
                flush  = 1'b1;
                accept = 1'b1;
            end
            if (i == 5) begin
                n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d required 0", count); end
                n_checks++; if (coin_reject !== 1'b1) begin n_fail++; $display("FAIL flush_reject: got %b required 1", coin_reject); end
                n_checks++; if (deposited !== 1'b0) begin n_fail++; $display("FAIL flush_deposited: got %b required 0", deposited); end
                n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b required 1", empty); end
                flush = 1'b0;
            end
            if (i == 6) coin_sense = 1'b0;
        end
        repeat (8) @(negedge clk);
        n_checks++; if (dep_log.size() !== 0) begin n_fail++; $display("FAIL flush_no_output: got %0d pulses required 0", dep_log.size()); end
        insert_coin(3'd3, rej);
        repeat (3) @(negedge clk);
        n_checks++; if (dep_log.size() !== 1) begin n_fail++; $display("FAIL flush_after_coin: got %0d pulses required 1", dep_log.size()); end
        else begin
            n_checks++; if (dep_log[0] !== 10'd50) begin n_fail++; $display("FAIL flush_after_value: got %0d required 50", dep_log[0]); end
        end
    endtask

    task automatic test_reset_midway();
        int rej;
        accept = 1'b0;
        insert_coin(3'd1, rej);
        insert_coin(3'd2, rej);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL mid_pre_count: got %0d required 2", count); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d required 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b required 1", empty); end
        n_checks++; if (deposit !== 10'd0) begin n_fail++; $display("FAIL mid_deposit: got %0d required 0", deposit); end
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        dep_log.delete();
        accept = 1'b1;
        insert_coin(3'd4, rej);
        repeat (3) @(negedge clk);
        n_checks++; if (dep_log.size() !== 1) begin n_fail++; $display("FAIL mid_after_coin: got %0d pulses required 1", dep_log.size()); end
        else begin
            n_checks++; if (dep_log[0] !== 10'd100) begin n_fail++; $display("FAIL mid_after_value: got %0d required 100", dep_log[0]); end
        end
    endtask

    initial begin
        rst        = 1'b0;
        coin_sense = 1'b1;
        coin_type  = 3'd0;
        accept     = 1'b0;
        flush      = 1'b0;
        test_reset();
        test_glitch();
        test_invalid();
        test_full();
        test_wrap();
        test_push_pop();
        test_flush();
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage directly upstream of the vending-machine controller.
- Debounces the raw coin-sensor level and classifies the coin type into a value in sen.
- Buffers accepted coins in a small FIFO.
- Delivers coins one at a time on the controller's deposit/deposited inputs, only when the controller signals it can take a coin. Invalid coins and overflow coins are rejected back to the coin return.

Parameters:
DEPTH, 4, FIFO entries (power of 2, 2..16)
DEBOUNCE, 4, consecutive identical samples needed to accept a sensor edge (>=2)
GAP, 2, idle cycles forced after each deposited pulse (>=0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
coin_sense  in  1  raw coin sensor level, high while coin in slot
coin_type  in  3  coin code from sensor, valid while coin_sense high
accept  in  1  controller can take a deposit this cycle
flush  in  1  synchronous clear of buffered coins
deposit  out  10  value of coin presented, in sen
deposited  out  1  one-cycle strobe: deposit valid, coin consumed
coin_reject  out  1  one-cycle strobe: coin diverted to return chute
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset, rst low, asynchronous:
  - All outputs 0, except empty=1.
  - FIFO pointers and count 0; gap counter 0.
  - Debounce FSM enters LOCK.
- Debounce FSM (states LOCK, IDLE, RISE, HELD, FALL):
  - LOCK: needs DEBOUNCE consecutive low samples -> IDLE. This prevents a phantom coin if the sensor is high at reset release.
  - IDLE: sample high -> RISE with counter=1.
  - RISE: high samples increment the counter; a low sample -> IDLE. When the counter reaches DEBOUNCE -> HELD and raise the internal coin event for one cycle, capturing coin_type on that same edge.
  - HELD: low sample -> FALL with counter=1.
  - FALL: low samples increment the counter; a high sample -> HELD. When the counter reaches DEBOUNCE -> IDLE.
  - Net effect: exactly one event per debounced high pulse.
- Classification, registered on the event edge:
  - Code 0=5, 1=10, 2=20, 3=50, 4=100. Codes 5..7 are invalid.
  - Valid coin and not full -> written to FIFO on the next edge.
  - Invalid code, or full at the write edge -> coin_reject high for exactly that one cycle; FIFO unchanged.
- Output pop:
  - Occurs on an edge where empty=0, accept=1, gap counter=0 and flush=0.
  - deposit <= head value and deposited <= 1 for one cycle; the entry is removed on the same edge; the gap counter loads GAP.
  - deposit holds its last value while deposited=0.
  - The gap counter decrements to 0 when nonzero.
- Minimum latency: debounced event edge E -> FIFO write at edge E+1 -> deposited high in the cycle after edge E+2, when accept is held and the gap is clear.
- Simultaneous push and pop:
  - When not full, count is unchanged and data is preserved in FIFO order.
  - When full, the push is rejected (full is evaluated on the registered count before the pop).
- Pointer wrap: modulo DEPTH; ordering is strict FIFO across wrap.
- flush=1:
  - Count, pointers and gap are cleared next edge; no deposited that cycle.
  - A coin write landing on the same edge is dropped with coin_reject=1.
  - The debounce FSM is unaffected.
- accept low: coins are held indefinitely; deposited is never asserted.
- rst asserted mid-operation: buffered coins are lost; outputs return to reset values immediately.

Test Plan:
- Reset with coin_sense=1, release, hold high 10 cycles, then low -> no event and no deposited until low for DEBOUNCE cycles; then a clean coin is accepted.
- Glitch: coin_sense high 3 cycles, low, then high 6 cycles with type 3, accept=1 -> exactly one deposited with deposit=50 at the minimum latency.
- Type 6 coin -> coin_reject 1-cycle pulse, count stays 0, no deposited.
- accept=0, insert types 0,1,2,4,3 -> count 4, full=1, fifth coin rejected; raise accept -> deposited pulses carry 5,10,20,100, separated by GAP idle cycles, then empty=1.
- Insert 6 coins across pops so pointers wrap -> values emitted in insertion order, count never exceeds DEPTH.
- Hold 2 coins, pulse flush on the same edge a third coin would be written -> count 0, coin_reject=1, no deposited afterward.
